// File: rtl/mdom_wvb_hdr_serializer_if.sv
// Header-FIFO side and framed word-stream side of the header serializer.
// master = serializer, slave = FIFO/readout environment.
interface mdom_wvb_hdr_serializer_if;
   logic          en;
   logic [103:0]  hdr_bundle;
   logic          hdr_empty;
   logic          hdr_rdreq;
   logic [15:0]   dout;
   logic          dout_valid;
   logic          dout_ready;
   logic          dout_last;
   logic          busy;
   logic [15:0]   frame_cnt;

   modport master (
      input  en, hdr_bundle, hdr_empty, dout_ready,
      output hdr_rdreq, dout, dout_valid, dout_last, busy, frame_cnt
   );

   modport slave (
      output en, hdr_bundle, hdr_empty, dout_ready,
      input  hdr_rdreq, dout, dout_valid, dout_last, busy, frame_cnt
   );
endinterface

// File: rtl/mdom_wvb_hdr_serializer.sv
// Pops one 104-bit waveform header and emits it as a framed 16-bit stream:
// sync word, 7 payload words (low word first), then an XOR checksum word.
module mdom_wvb_hdr_serializer #(
   parameter logic [15:0] P_SYNC_WORD = 16'h5A5A,
   parameter int          P_BUNDLE_W  = 104,
   parameter int          P_WORD_W    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   mdom_wvb_hdr_serializer_if.master     bus
);

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      PAYLOAD,
      CKSUM
   } state_t;

   localparam logic [2:0] LAST_IDX = 3'd6;

   state_t                  state, state_nxt;
   logic [P_BUNDLE_W-1:0]   shift_reg, shift_nxt;
   logic [P_WORD_W-1:0]     cksum, cksum_nxt;
   logic [P_WORD_W-1:0]     dout_q, dout_nxt;
   logic [15:0]             frame_cnt_q, cnt_nxt;
   logic [2:0]              word_idx, idx_nxt;
   logic                    valid_q, valid_nxt;
   logic                    last_q, last_nxt;
   logic                    pop;
   logic                    accept;

   assign pop    = (state == IDLE) && bus.en && !bus.hdr_empty && !rst;
   assign accept = valid_q && bus.dout_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         shift_reg   <= '0;
         cksum       <= '0;
         dout_q      <= '0;
         frame_cnt_q <= '0;
         word_idx    <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         shift_reg   <= shift_nxt;
         cksum       <= cksum_nxt;
         dout_q      <= dout_nxt;
         frame_cnt_q <= cnt_nxt;
         word_idx    <= idx_nxt;
         valid_q     <= valid_nxt;
         last_q      <= last_nxt;
      end
   end

   // The bundle shifts down one word per accepted payload word, so the next
   // word is always in the low slice; zero fill gives word 6 its 8'h00 pad.
   always_comb begin
      state_nxt = state;
      shift_nxt = shift_reg;
      cksum_nxt = cksum;
      dout_nxt  = dout_q;
      cnt_nxt   = frame_cnt_q;
      idx_nxt   = word_idx;
      valid_nxt = valid_q;
      last_nxt  = last_q;

      case (state)
         IDLE: begin
            if (pop) begin
               shift_nxt = bus.hdr_bundle;
               cksum_nxt = '0;
               idx_nxt   = '0;
               dout_nxt  = P_SYNC_WORD;
               valid_nxt = 1'b1;
               last_nxt  = 1'b0;
               state_nxt = SYNC;
            end
         end
         SYNC: begin
            if (accept) begin
               dout_nxt  = shift_reg[P_WORD_W-1:0];
               shift_nxt = shift_reg >> P_WORD_W;
               state_nxt = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (accept) begin
               cksum_nxt = cksum ^ dout_q;
               if (word_idx == LAST_IDX) begin
                  dout_nxt  = cksum ^ dout_q;
                  last_nxt  = 1'b1;
                  state_nxt = CKSUM;
               end else begin
                  dout_nxt  = shift_reg[P_WORD_W-1:0];
                  shift_nxt = shift_reg >> P_WORD_W;
                  idx_nxt   = word_idx + 3'd1;
               end
            end
         end
         CKSUM: begin
            if (accept) begin
               cnt_nxt   = frame_cnt_q + 16'd1;
               dout_nxt  = '0;
               valid_nxt = 1'b0;
               last_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.hdr_rdreq  = pop;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = valid_q;
   assign bus.dout_last  = last_q;
   assign bus.busy       = (state != IDLE);
   assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_mdom_wvb_hdr_serializer.sv
// Directed + randomized bench for the header serializer; expected words come
// from a frame model built directly from the bundle with plain arithmetic.
module tb_mdom_wvb_hdr_serializer;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mdom_wvb_hdr_serializer_if bus();

   mdom_wvb_hdr_serializer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   int           pop_cyc[$];
   logic [103:0] fifo[$];
   logic [15:0]  exp_word[$];
   logic         exp_last[$];
   logic [15:0]  model_cnt;
   logic [15:0]  last_acc_word;
   logic         en_drv;
   logic         s_rdreq, s_valid, s_last, s_busy;
   logic [15:0]  s_dout, s_cnt;
   logic [103:0] bundle1;
   int           p0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
         $error("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One frame as seen on the wire: sync, seven 16-bit slices of the bundle
   // (top slice zero-padded), then the XOR of those seven slices.
   function automatic void modelFrame(input logic [103:0] b);
      logic [127:0] wide;
      logic [15:0]  w;
      logic [15:0]  ck;
      wide = {24'h0, b};
      ck   = 16'h0;
      exp_word.push_back(16'h5A5A);
      exp_last.push_back(1'b0);
      for (int k = 0; k < 7; k++) begin
         w  = wide[16*k +: 16];
         ck = ck ^ w;
         exp_word.push_back(w);
         exp_last.push_back(1'b0);
      end
      exp_word.push_back(ck);
      exp_last.push_back(1'b1);
   endfunction

   function automatic logic [103:0] randBundle();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[103:0];
   endfunction

   // Called at a negedge: drive inputs, sample and score outputs, step one cycle.
   task automatic applyStimulus(input logic rdy);
      logic exp_busy, exp_rdreq;
      bus.en         = en_drv;
      bus.dout_ready = rdy;
      bus.hdr_empty  = (fifo.size() == 0);
      bus.hdr_bundle = (fifo.size() != 0) ? fifo[0] : 104'h0;
      #1;
      s_rdreq = bus.hdr_rdreq;
      s_valid = bus.dout_valid;
      s_last  = bus.dout_last;
      s_busy  = bus.busy;
      s_dout  = bus.dout;
      s_cnt   = bus.frame_cnt;
      exp_busy  = (exp_word.size() != 0);
      exp_rdreq = !exp_busy && en_drv && (fifo.size() != 0);
      checkOutput("dout_valid", {31'h0, s_valid}, {31'h0, exp_busy});
      checkOutput("busy", {31'h0, s_busy}, {31'h0, exp_busy});
      checkOutput("hdr_rdreq", {31'h0, s_rdreq}, {31'h0, exp_rdreq});
      checkOutput("frame_cnt", {16'h0, s_cnt}, {16'h0, model_cnt});
      if (s_valid && exp_busy) begin
         checkOutput("dout", {16'h0, s_dout}, {16'h0, exp_word[0]});
         checkOutput("dout_last", {31'h0, s_last}, {31'h0, exp_last[0]});
         if (rdy) begin
            if (exp_last[0]) model_cnt = model_cnt + 16'd1;
            last_acc_word = s_dout;
            void'(exp_word.pop_front());
            void'(exp_last.pop_front());
         end
      end
      if (s_rdreq && fifo.size() != 0) begin
         modelFrame(fifo[0]);
         pop_cyc.push_back(cyc);
         void'(fifo.pop_front());
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   // mode 0: ready=1, mode 1: ready pattern 1,0,0, mode 2: random ready
   task automatic runFrames(input string tag, input int max_cyc, input int mode);
      logic rdy;
      bit   done;
      done = 0;
      for (int i = 0; i < max_cyc; i++) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((i % 3) == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         applyStimulus(rdy);
         if (exp_word.size() == 0 && (fifo.size() == 0 || !en_drv)) begin
            done = 1;
            break;
         end
      end
      if (!done) checkOutput({"timeout_", tag}, 32'd0, 32'd1);
   endtask

   task automatic stepUntilRemaining(input string tag, input int n, input int max_cyc);
      bit done;
      done = 0;
      for (int i = 0; i < max_cyc; i++) begin
         applyStimulus(1'b1);
         if (exp_word.size() == n) begin
            done = 1;
            break;
         end
      end
      if (!done) checkOutput({"timeout_", tag}, 32'd0, 32'd1);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_valid"}, {31'h0, bus.dout_valid}, 32'd0);
      checkOutput({tag, "_dout"}, {16'h0, bus.dout}, 32'd0);
      checkOutput({tag, "_last"}, {31'h0, bus.dout_last}, 32'd0);
      checkOutput({tag, "_busy"}, {31'h0, bus.busy}, 32'd0);
      checkOutput({tag, "_rdreq"}, {31'h0, bus.hdr_rdreq}, 32'd0);
      checkOutput({tag, "_cnt"}, {16'h0, bus.frame_cnt}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst            = 1'b1;
      en_drv         = 1'b1;
      model_cnt      = 16'h0;
      last_acc_word  = 16'h0;
      bundle1        = 104'h0;
      bundle1[15:0]  = 16'h1234;
      bundle1[103:96] = 8'hFF;
      fifo.push_back(bundle1);
      bus.en         = 1'b1;
      bus.dout_ready = 1'b1;
      bus.hdr_empty  = 1'b0;
      bus.hdr_bundle = bundle1;

      // Reset state, with a header waiting and en high
      @(negedge clk);
      @(negedge clk);
      #1;
      checkResetOutputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Single frame, ready held high
      p0 = pop_cyc.size();
      runFrames("single", 40, 0);
      applyStimulus(1'b1);
      checkOutput("t1_pops", pop_cyc.size() - p0, 32'd1);
      checkOutput("t1_cksum", {16'h0, last_acc_word}, 32'h12CB);
      checkOutput("t1_frame_cnt", {16'h0, s_cnt}, 32'd1);

      // Same frame under 1,0,0 backpressure
      fifo.push_back(bundle1);
      runFrames("backpressure", 80, 1);
      applyStimulus(1'b1);
      checkOutput("t2_cksum", {16'h0, last_acc_word}, 32'h12CB);
      checkOutput("t2_frame_cnt", {16'h0, s_cnt}, 32'd2);

      // Three random headers back to back
      p0 = pop_cyc.size();
      for (int i = 0; i < 3; i++) fifo.push_back(randBundle());
      runFrames("b2b", 100, 0);
      applyStimulus(1'b1);
      checkOutput("t3_pops", pop_cyc.size() - p0, 32'd3);
      if (pop_cyc.size() - p0 == 3) begin
         checkOutput("t3_gap1", pop_cyc[p0+1] - pop_cyc[p0], 32'd10);
         checkOutput("t3_gap2", pop_cyc[p0+2] - pop_cyc[p0+1], 32'd10);
      end
      checkOutput("t3_frame_cnt", {16'h0, s_cnt}, 32'd5);

      // Enable gating, then en dropped on the third word
      en_drv = 1'b0;
      fifo.push_back(randBundle());
      for (int i = 0; i < 5; i++) applyStimulus(1'b1);
      checkOutput("t4_gated_fifo", fifo.size(), 32'd1);
      en_drv = 1'b1;
      p0 = pop_cyc.size();
      stepUntilRemaining("t4_third", 7, 20);
      fifo.push_back(randBundle());
      en_drv = 1'b0;
      runFrames("en_drop", 40, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1);
      checkOutput("t4_pops", pop_cyc.size() - p0, 32'd1);
      checkOutput("t4_fifo_left", fifo.size(), 32'd1);
      checkOutput("t4_frame_cnt", {16'h0, s_cnt}, 32'd6);

      // Reset while payload word 4 is on the bus
      en_drv = 1'b1;
      stepUntilRemaining("t5_word4", 4, 30);
      fifo.push_back(randBundle());
      rst = 1'b1;
      #1;
      checkResetOutputs("midreset");
      exp_word.delete();
      exp_last.delete();
      model_cnt = 16'h0;
      @(negedge clk);
      rst = 1'b0;
      p0 = pop_cyc.size();
      runFrames("after_reset", 40, 0);
      applyStimulus(1'b1);
      checkOutput("t5_pops", pop_cyc.size() - p0, 32'd1);
      checkOutput("t5_frame_cnt", {16'h0, s_cnt}, 32'd1);

      // Counter wrap: preload 16'hFFFF while idle
      force dut.frame_cnt_q = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.frame_cnt_q;
      model_cnt = 16'hFFFF;
      fifo.push_back(randBundle());
      runFrames("wrap", 200, 2);
      applyStimulus(1'b1);
      checkOutput("t6_frame_cnt_wrap", {16'h0, s_cnt}, 32'd0);

      // Random headers under random backpressure
      for (int i = 0; i < 4; i++) fifo.push_back(randBundle());
      runFrames("random", 400, 2);
      applyStimulus(1'b1);
      checkOutput("t7_frame_cnt", {16'h0, s_cnt}, 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
